fft_bfly_pipe: RTL

Parametrised, pipelined radix-2 decimation-in-time butterfly for the FFT datapath. It computes c = (a + b·w) / 2^s and d = (a − b·w) / 2^s on complex fixed-point samples. The twiddle w is supplied per transaction, so one block serves every FFT stage, and the fixed-function butterflies with hard-wired twiddle constants are no longer needed. It adds valid/ready flow control, per-transaction scaling, round-half-up and overflow detection, and is chained stage-to-stage by the FFT controller.

---
 rtl/fft_bfly_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: 3-stage radix-2 DIT butterfly, c/d = (a +/- b*w) / 2^s, round-half-up, sticky overflow.
// Build option: define BFLY_SAT_EN to clamp out-of-range results instead of wrapping them.
module fft_bfly_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TW_W   = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     bypass,
    input  logic                     scale,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] c_re,
    output logic signed [DATA_W-1:0] c_im,
    output logic signed [DATA_W-1:0] d_re,
    output logic signed [DATA_W-1:0] d_im,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int unsigned F  = TW_W - 2;
    localparam int unsigned PW = DATA_W + TW_W;
    localparam int unsigned AW = DATA_W + F;
    localparam int unsigned XW = PW + 2;
    localparam int unsigned RW = XW + 1;

    localparam logic signed [RW-1:0] RND0  = RW'(1) << (F - 1);
    localparam logic signed [RW-1:0] RND1  = RW'(1) << F;
    localparam logic signed [RW-1:0] R_MAX = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RW-1:0] R_MIN = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic adv;

    logic                 s1_valid, s1_scale;
    logic signed [PW-1:0] s1_p0, s1_p1, s1_p2, s1_p3;
    logic signed [AW-1:0] s1_a_re, s1_a_im;
    logic signed [PW-1:0] p0_n, p1_n, p2_n, p3_n;

    logic                 s2_valid, s2_scale;
    logic signed [XW-1:0] s2_c_re, s2_c_im, s2_d_re, s2_d_im;
    logic signed [XW-1:0] t_re, t_im;

    logic signed [RW-1:0] r_c_re, r_c_im, r_d_re, r_d_im;
    logic                 any_oor;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    function automatic logic signed [RW-1:0] round_shift(input logic signed [XW-1:0] x,
                                                         input logic s);
        logic signed [RW-1:0] y;
        y = RW'(x) + (s ? RND1 : RND0);
        return s ? (y >>> (F + 1)) : (y >>> F);
    endfunction

    function automatic logic out_of_range(input logic signed [RW-1:0] r);
        return (r > R_MAX) || (r < R_MIN);
    endfunction

    function automatic logic [DATA_W-1:0] fit(input logic signed [RW-1:0] r);
`ifdef BFLY_SAT_EN
        if (r > R_MAX) return {1'b0, {(DATA_W-1){1'b1}}};
        if (r < R_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
`endif
        return r[DATA_W-1:0];
    endfunction

    // Stage 1 products; bypass substitutes b scaled to the twiddle's Q point.
    always_comb begin
        p0_n = PW'(b_re) <<< F;
        p1_n = '0;
        p2_n = '0;
        p3_n = PW'(b_im) <<< F;
        if (!bypass) begin
            p0_n = PW'(b_re) * PW'(w_re);
            p1_n = PW'(b_im) * PW'(w_im);
            p2_n = PW'(b_re) * PW'(w_im);
            p3_n = PW'(b_im) * PW'(w_re);
        end
    end

    always_comb begin
        t_re = XW'(s1_p0) - XW'(s1_p1);
        t_im = XW'(s1_p2) + XW'(s1_p3);
    end

    always_comb begin
        r_c_re  = round_shift(s2_c_re, s2_scale);
        r_c_im  = round_shift(s2_c_im, s2_scale);
        r_d_re  = round_shift(s2_d_re, s2_scale);
        r_d_im  = round_shift(s2_d_im, s2_scale);
        any_oor = out_of_range(r_c_re) || out_of_range(r_c_im) ||
                  out_of_range(r_d_re) || out_of_range(r_d_im);
    end

    // Stage valids: reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_scale <= scale;
            s1_p0    <= p0_n;
            s1_p1    <= p1_n;
            s1_p2    <= p2_n;
            s1_p3    <= p3_n;
            s1_a_re  <= AW'(a_re) <<< F;
            s1_a_im  <= AW'(a_im) <<< F;
            s2_scale <= s1_scale;
            s2_c_re  <= XW'(s1_a_re) + t_re;
            s2_c_im  <= XW'(s1_a_im) + t_im;
            s2_d_re  <= XW'(s1_a_re) - t_re;
            s2_d_im  <= XW'(s1_a_im) - t_im;
        end
    end

    // Stage 3 is the output register; ovf set beats ovf_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            c_re      <= '0;
            c_im      <= '0;
            d_re      <= '0;
            d_im      <= '0;
            ovf       <= 1'b0;
        end else begin
            if (adv) begin
                out_valid <= s2_valid;
                c_re      <= fit(r_c_re);
                c_im      <= fit(r_c_im);
                d_re      <= fit(r_d_re);
                d_im      <= fit(r_d_im);
            end
            if (adv && s2_valid && any_oor) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
